// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory, decode and the redirect source.
// master = fetch unit side, slave = environment side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    input  imem_ack, imem_rdata, dec_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc,
    output imem_ack, imem_rdata, dec_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: one outstanding imem request at a time, a small {instr, pc}
// queue towards decode, and redirect handling that flushes the queue and drops stale data.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_1000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t           r_state, w_state_next;
  logic             r_req, w_req_next;
  logic [31:0]      r_addr, w_addr_next;
  logic [31:0]      r_fetch_pc, w_fetch_pc_next;
  logic [31:0]      r_instr_mem [QUEUE_DEPTH];
  logic [31:0]      r_pc_mem    [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count, w_count_next;
  logic [31:0]      w_redirect_pc;
  logic             w_has_head, w_push, w_pop, w_space_after;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;
  assign w_has_head    = (r_count != '0);
  // Decode never sees the head during a redirect cycle, so nothing is popped then.
  assign w_pop         = w_has_head && !bus.redirect && bus.dec_ready;
  assign w_push        = (r_state == REQ) && bus.imem_ack && !bus.redirect;

  always_comb begin
    w_count_next = r_count;
    if (bus.redirect) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  assign w_space_after = (w_count_next < DEPTH_C);

  always_comb begin
    w_state_next    = r_state;
    w_req_next      = r_req;
    w_addr_next     = r_addr;
    w_fetch_pc_next = r_fetch_pc;
    case (r_state)
      IDLE: begin
        if (bus.redirect) begin
          w_fetch_pc_next = w_redirect_pc;
        end else if (r_count < DEPTH_C) begin
          w_req_next   = 1'b1;
          w_addr_next  = r_fetch_pc;
          w_state_next = REQ;
        end
      end
      REQ: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            // Response is stale but the bus is free: go straight to the new target.
            w_fetch_pc_next = w_redirect_pc;
            w_addr_next     = w_redirect_pc;
          end else begin
            w_fetch_pc_next = r_fetch_pc + 32'd4;
            if (w_space_after) begin
              w_addr_next = r_fetch_pc + 32'd4;
            end else begin
              w_req_next   = 1'b0;
              w_state_next = IDLE;
            end
          end
        end else if (bus.redirect) begin
          w_fetch_pc_next = w_redirect_pc;
          w_state_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.redirect) begin
          w_fetch_pc_next = w_redirect_pc;
        end
        if (bus.imem_ack) begin
          w_addr_next  = bus.redirect ? w_redirect_pc : r_fetch_pc;
          w_state_next = REQ;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_req      <= w_req_next;
      r_addr     <= w_addr_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_count    <= w_count_next;
      if (bus.redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
        if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= bus.imem_rdata;
      r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
    end
  end

  assign bus.imem_req  = r_req;
  assign bus.imem_addr = r_addr;
  assign bus.dec_valid = w_has_head && !bus.redirect;
  assign bus.dec_instr = w_has_head ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign bus.dec_pc    = w_has_head ? r_pc_mem[r_rd_ptr] : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: randomized memory latency, backpressure and redirects
// checked against a queue-level model of the delivered {pc, instr} stream.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam int          DEPTH    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  fetch_unit_if bus_if();

  fetch_unit #(.RESET_PC(RESET_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory content is a bijective function of the address, so any word tells its origin.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory responder: lat_fixed < 0 selects a random 0..3 cycle wait per request.
  int lat_fixed = -1;
  int wait_cnt  = 0;

  initial begin
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus_if.imem_ack   = ~bus_if.imem_ack;
        bus_if.imem_rdata = $urandom;
        wait_cnt          = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end else if (bus_if.imem_ack) begin
        bus_if.imem_ack = 1'b0;
        wait_cnt        = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
      end else if (bus_if.imem_req) begin
        if (wait_cnt == 0) begin
          bus_if.imem_ack   = 1'b1;
          bus_if.imem_rdata = mem_word(bus_if.imem_addr);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // Reference model: the stream after the latest redirect is pc, pc+4, ... with mem_word(pc).
  logic        model_en = 1'b0;
  int          cnt_exp;
  logic [31:0] exp_pc, req_pc_exp, last_pc, tgt;
  logic        stale, prev_valid, prev_req, prev_ack, prev_redir;
  logic [31:0] prev_addr;
  int          prev_cnt, pop_m, live_m;
  int          live_acks = 0;
  int          delivered = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cnt_exp    = 0;
      exp_pc     = RESET_PC;
      req_pc_exp = RESET_PC;
      stale      = 1'b0;
      prev_valid = 1'b0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
      prev_redir = 1'b0;
      prev_addr  = 32'h0;
      prev_cnt   = 0;
    end else if (model_en) begin
      pop_m  = (cnt_exp > 0 && !bus_if.redirect && bus_if.dec_ready) ? 1 : 0;
      live_m = 0;
      tgt    = {bus_if.redirect_pc[31:2], 2'b00};
      if (prev_valid && prev_req && !prev_ack) begin
        check("req_hold", 32'(bus_if.imem_req), 32'd1);
        check("addr_stable", bus_if.imem_addr, prev_addr);
      end
      if (prev_valid && !prev_req && !prev_redir && prev_cnt < DEPTH)
        check("req_issue", 32'(bus_if.imem_req), 32'd1);
      if (bus_if.redirect) check("redir_valid", 32'(bus_if.dec_valid), 32'd0);
      else                 check("valid", 32'(bus_if.dec_valid), 32'(cnt_exp != 0));
      if (bus_if.imem_req && !stale) check("req_addr", bus_if.imem_addr, req_pc_exp);
      if (pop_m != 0) begin
        check("dec_pc", bus_if.dec_pc, exp_pc);
        check("dec_instr", bus_if.dec_instr, mem_word(exp_pc));
        $display("deliver pc=%h instr=%h", bus_if.dec_pc, bus_if.dec_instr);
        last_pc = bus_if.dec_pc;
        delivered++;
        exp_pc = exp_pc + 32'd4;
      end
      if (bus_if.imem_ack && bus_if.imem_req) begin
        if (stale || bus_if.redirect) begin
          stale = 1'b0;
        end else begin
          live_m = 1;
          check("no_overflow", 32'((cnt_exp - pop_m) < DEPTH), 32'd1);
          live_acks++;
          req_pc_exp = req_pc_exp + 32'd4;
        end
      end
      prev_cnt = cnt_exp;
      if (bus_if.redirect) begin
        if (bus_if.imem_req && !bus_if.imem_ack) stale = 1'b1;
        cnt_exp    = 0;
        exp_pc     = tgt;
        req_pc_exp = tgt;
      end else begin
        cnt_exp = cnt_exp + live_m - pop_m;
      end
      prev_valid = 1'b1;
      prev_req   = bus_if.imem_req;
      prev_ack   = bus_if.imem_ack;
      prev_redir = bus_if.redirect;
      prev_addr  = bus_if.imem_addr;
    end
  end

  task automatic wait_req(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus_if.imem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_deliver(input int target, input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
      if (delivered >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = pc;
    @(posedge clk);
    #2;
    bus_if.redirect = 1'b0;
  endtask

  bit ok;
  int base;

  initial begin
    bus_if.dec_ready   = 1'b0;
    bus_if.redirect    = 1'b0;
    bus_if.redirect_pc = 32'h0;

    // Reset held with imem_ack toggling
    repeat (4) @(posedge clk);
    #3;
    check("rst_req", 32'(bus_if.imem_req), 32'd0);
    check("rst_valid", 32'(bus_if.dec_valid), 32'd0);
    check("rst_addr", bus_if.imem_addr, RESET_PC);
    check("rst_instr", bus_if.dec_instr, 32'h0);
    check("rst_pc", bus_if.dec_pc, 32'h0);
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    model_en = 1'b1;
    wait_req(10, ok);
    check("first_req", 32'(ok), 32'd1);
    check("first_addr", bus_if.imem_addr, 32'h0000_1000);

    // Sequential fetch with decode always ready
    bus_if.dec_ready = 1'b1;
    wait_deliver(3, 60, ok);
    check("seq_progress", 32'(ok), 32'd1);

    // Backpressure: exactly DEPTH requests complete, then the request line drops
    bus_if.dec_ready = 1'b0;
    lat_fixed        = 0;
    do_reset();
    base = live_acks;
    repeat (20) @(posedge clk);
    #2;
    check("bp_acks", 32'(live_acks - base), 32'(DEPTH));
    check("bp_req_low", 32'(bus_if.imem_req), 32'd0);
    bus_if.dec_ready = 1'b1;
    wait_req(10, ok);
    check("bp_resume", 32'(ok), 32'd1);
    check("bp_resume_addr", bus_if.imem_addr, 32'h0000_1008);

    // Redirect while a request is pending: response must be drained and discarded
    lat_fixed = 2;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      if (bus_if.imem_req && !bus_if.imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_setup", 32'(ok), 32'd1);
    pulse_redirect(32'h0000_2003);
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_if.imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain_ack", 32'(ok), 32'd1);
    @(negedge clk);
    check("drain_req", 32'(bus_if.imem_req), 32'd1);
    check("drain_addr", bus_if.imem_addr, 32'h0000_2000);

    // Redirect in the same cycle as ack: no drain, data dropped
    lat_fixed = 1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #2;
      if (bus_if.imem_ack) begin
        ok = 1'b1;
        break;
      end
    end
    check("same_setup", 32'(ok), 32'd1);
    bus_if.redirect    = 1'b1;
    bus_if.redirect_pc = 32'h0000_3000;
    @(negedge clk);
    check("same_valid", 32'(bus_if.dec_valid), 32'd0);
    @(posedge clk);
    #2;
    bus_if.redirect = 1'b0;
    @(negedge clk);
    check("same_req", 32'(bus_if.imem_req), 32'd1);
    check("same_addr", bus_if.imem_addr, 32'h0000_3000);

    // Randomized traffic: latency, backpressure and redirects
    lat_fixed = -1;
    base      = delivered;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #2;
      bus_if.dec_ready = ($urandom_range(0, 9) < 7);
      if (!bus_if.redirect && $urandom_range(0, 19) == 0) begin
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                          : $urandom;
      end else begin
        bus_if.redirect = 1'b0;
      end
    end
    @(posedge clk);
    #2;
    bus_if.redirect = 1'b0;
    check("rand_progress", 32'((delivered - base) > 60), 32'd1);

    // PC wrap-around
    bus_if.dec_ready = 1'b1;
    pulse_redirect(32'hFFFF_FFFC);
    base = delivered;
    wait_deliver(base + 1, 40, ok);
    check("wrap_first", last_pc, 32'hFFFF_FFFC);
    wait_deliver(base + 2, 40, ok);
    check("wrap_second", last_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a request
    wait_req(20, ok);
    check("async_setup", 32'(ok), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_req", 32'(bus_if.imem_req), 32'd0);
    check("async_addr", bus_if.imem_addr, RESET_PC);
    check("async_valid", 32'(bus_if.dec_valid), 32'd0);
    check("async_instr", bus_if.dec_instr, 32'h0);
    check("async_pc", bus_if.dec_pc, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
